// File: rtl/axi_rd_pkg.sv
// Shared definitions for the strided AXI read engine: FSM states and
// errorCode bit positions.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } rd_state_t;

  localparam int ERR_BITS       = 3;
  localparam int ERR_ID         = 0;
  localparam int ERR_EARLY_LAST = 1;
  localparam int ERR_NO_LAST    = 2;

endpackage

// File: rtl/axi_rd_beat_checker.sv
// R-channel monitor: tracks the beat index inside the current burst, flags
// protocol errors, and accumulates beat count and XOR checksum.
module axi_rd_beat_checker
  import axi_rd_pkg::*;
#(
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
  input  logic [TID_WIDTH-1:0]       cfg_id,
  input  logic                       r_valid,
  input  logic                       r_ready,
  input  logic                       r_last,
  input  logic [DATA_WIDTH-1:0]      r_data,
  input  logic [TID_WIDTH-1:0]       r_id,
  input  logic                       none_outstanding,
  output logic                       burst_close,
  output logic [ERR_BITS-1:0]        error_code,
  output logic [CNT_WIDTH-1:0]       beat_cnt,
  output logic [DATA_WIDTH-1:0]      checksum
);

  logic                       r_hs;
  logic                       beat_ok;
  logic                       at_end;
  logic [BURST_LEN_WIDTH-1:0] beat_idx;

  assign r_hs    = r_valid & r_ready;
  // A beat with nothing outstanding has no burst to belong to.
  assign beat_ok = r_hs & ~none_outstanding;
  assign at_end  = (beat_idx == cfg_len);
  assign burst_close = beat_ok & (r_last | at_end);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_idx   <= '0;
      error_code <= '0;
      beat_cnt   <= '0;
      checksum   <= '0;
    end else begin
      if (r_hs && (r_id != cfg_id))
        error_code[ERR_ID] <= 1'b1;
      if (r_hs && none_outstanding)
        error_code[ERR_EARLY_LAST] <= 1'b1;
      if (beat_ok) begin
        if (beat_cnt != '1)
          beat_cnt <= beat_cnt + 1'b1;
        checksum <= checksum ^ r_data;
        if (r_last) begin
          if (!at_end)
            error_code[ERR_EARLY_LAST] <= 1'b1;
          beat_idx <= '0;
        end else if (at_end) begin
          // Missing last: close the burst anyway so the run can drain.
          error_code[ERR_NO_LAST] <= 1'b1;
          beat_idx <= '0;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_stride_reader.sv
// Issues cfg_req_num AXI read bursts at base + k*stride with a bounded number
// outstanding, and checks/accumulates the returned R beats.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_ISSUE  | issuing AR requests, R beats accepted
// ST_DRAIN  | all ARs issued, waiting for outstanding bursts to complete
// ST_FINISH | one-cycle done pulse
module axi_stride_reader
  import axi_rd_pkg::*;
#(
  parameter int ADDR_BITS            = 16,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int LOG_OUT_SIZE         = 3,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDR_BITS-1:0]                  cfg_base_addr,
  input  logic [ADDR_BITS-1:0]                  cfg_stride,
  input  logic [BURST_LEN_WIDTH-1:0]            cfg_len,
  input  logic [CNT_WIDTH-1:0]                  cfg_req_num,
  input  logic [TID_WIDTH-1:0]                  cfg_id,
  input  logic [LOG_OUT_SIZE:0]                 cfg_outstanding_limit,
  input  logic                                  r_stall,
  output logic                                  m_ar_valid,
  input  logic                                  m_ar_ready,
  output logic [ADDR_BITS-1:0]                  m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
  output logic [TID_WIDTH-1:0]                  m_ar_id,
  input  logic                                  m_r_valid,
  output logic                                  m_r_ready,
  input  logic                                  m_r_last,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
  input  logic [TID_WIDTH-1:0]                  m_r_id,
  output logic                                  busy,
  output logic                                  done,
  output logic [ERR_BITS-1:0]                   errorCode,
  output logic [CNT_WIDTH-1:0]                  beatCnt,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  dataChecksum
);

  localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int OUT_W      = LOG_OUT_SIZE + 1;

  rd_state_t state, state_nx;

  logic [ADDR_BITS-1:0] stride_q;
  logic [CNT_WIDTH-1:0] req_num_q;
  logic [OUT_W-1:0]     limit_q;
  logic [CNT_WIDTH-1:0] req_cnt;
  logic [CNT_WIDTH-1:0] req_cnt_inc;
  logic [CNT_WIDTH-1:0] issued_nx;
  logic [OUT_W-1:0]     out_cnt;
  logic [OUT_W-1:0]     out_nx;
  logic [OUT_W-1:0]     lim_eff;
  logic                 start_ok;
  logic                 ar_hs;
  logic                 burst_close;
  logic                 none_out;
  logic                 more_req;
  logic                 ar_valid_nx;

  assign start_ok    = start & (state == ST_IDLE);
  assign ar_hs       = m_ar_valid & m_ar_ready;
  assign none_out    = (out_cnt == '0);
  assign lim_eff     = (limit_q == '0) ? {{(OUT_W-1){1'b0}}, 1'b1} : limit_q;
  assign req_cnt_inc = (req_cnt == '1) ? req_cnt : req_cnt + 1'b1;
  assign issued_nx   = ar_hs ? req_cnt_inc : req_cnt;
  assign more_req    = (issued_nx < req_num_q);

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);
  assign m_r_ready = busy & ~r_stall;

  always_comb begin
    out_nx = out_cnt;
    if (ar_hs && !burst_close)
      out_nx = out_cnt + 1'b1;
    else if (!ar_hs && burst_close)
      out_nx = out_cnt - 1'b1;
  end

  // Valid is computed one cycle ahead from the next outstanding count, so the
  // limit holds without any combinational path from m_ar_ready.
  always_comb begin
    state_nx    = state;
    ar_valid_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx    = (cfg_req_num == '0) ? ST_FINISH : ST_ISSUE;
          ar_valid_nx = (cfg_req_num != '0);
        end
      end
      ST_ISSUE: begin
        if (!more_req)
          state_nx = ST_DRAIN;
        ar_valid_nx = more_req && (out_nx < lim_eff);
      end
      ST_DRAIN: begin
        if (none_out)
          state_nx = ST_FINISH;
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // m_ar_len / m_ar_id double as the latched run configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_id    <= '0;
      stride_q   <= '0;
      req_num_q  <= '0;
      limit_q    <= '0;
      req_cnt    <= '0;
      out_cnt    <= '0;
    end else begin
      state      <= state_nx;
      m_ar_valid <= ar_valid_nx;
      out_cnt    <= out_nx;
      if (start_ok) begin
        m_ar_addr <= cfg_base_addr;
        m_ar_len  <= cfg_len;
        m_ar_id   <= cfg_id;
        stride_q  <= cfg_stride;
        req_num_q <= cfg_req_num;
        limit_q   <= cfg_outstanding_limit;
        req_cnt   <= '0;
      end else if (ar_hs) begin
        m_ar_addr <= m_ar_addr + stride_q;
        req_cnt   <= req_cnt_inc;
      end
    end
  end

  axi_rd_beat_checker #(
    .BURST_LEN_WIDTH (BURST_LEN_WIDTH),
    .TID_WIDTH       (TID_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_beat_checker (
    .clk              (clk),
    .rst              (rst),
    .clear            (start_ok),
    .cfg_len          (m_ar_len),
    .cfg_id           (m_ar_id),
    .r_valid          (m_r_valid),
    .r_ready          (m_r_ready),
    .r_last           (m_r_last),
    .r_data           (m_r_data),
    .r_id             (m_r_id),
    .none_outstanding (none_out),
    .burst_close      (burst_close),
    .error_code       (errorCode),
    .beat_cnt         (beatCnt),
    .checksum         (dataChecksum)
  );

endmodule

// File: tb/tb_axi_stride_reader.sv
// Bench for axi_stride_reader: AXI RAM-like slave model, AR scoreboard and
// per-scenario result checks.
module tb_axi_stride_reader;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base_addr;
  logic [AW-1:0] cfg_stride;
  logic [7:0]    cfg_len;
  logic [15:0]   cfg_req_num;
  logic [7:0]    cfg_id;
  logic [3:0]    cfg_outstanding_limit;
  logic          r_stall;
  logic          m_ar_valid;
  logic          m_ar_ready;
  logic [AW-1:0] m_ar_addr;
  logic [7:0]    m_ar_len;
  logic [7:0]    m_ar_id;
  logic          m_r_valid;
  logic          m_r_ready;
  logic          m_r_last;
  logic [DW-1:0] m_r_data;
  logic [7:0]    m_r_id;
  logic          busy;
  logic          done;
  logic [2:0]    errorCode;
  logic [15:0]   beatCnt;
  logic [DW-1:0] dataChecksum;

  axi_stride_reader dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .cfg_base_addr         (cfg_base_addr),
    .cfg_stride            (cfg_stride),
    .cfg_len               (cfg_len),
    .cfg_req_num           (cfg_req_num),
    .cfg_id                (cfg_id),
    .cfg_outstanding_limit (cfg_outstanding_limit),
    .r_stall               (r_stall),
    .m_ar_valid            (m_ar_valid),
    .m_ar_ready            (m_ar_ready),
    .m_ar_addr             (m_ar_addr),
    .m_ar_len              (m_ar_len),
    .m_ar_id               (m_ar_id),
    .m_r_valid             (m_r_valid),
    .m_r_ready             (m_r_ready),
    .m_r_last              (m_r_last),
    .m_r_data              (m_r_data),
    .m_r_id                (m_r_id),
    .busy                  (busy),
    .done                  (done),
    .errorCode             (errorCode),
    .beatCnt               (beatCnt),
    .dataChecksum          (dataChecksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } burst_t;

  burst_t        rq[$];
  logic [AW-1:0] exp_ar[$];
  logic [7:0]    exp_len = 8'd0;
  logic [7:0]    exp_id = 8'd0;
  int            beat = 0;
  bit            r_en = 1'b1;
  bit            ar_ready_en = 1'b1;
  int            ar_stall_cycles = 0;
  int            inj_id_beat = -1;
  logic [7:0]    inj_id = 8'd0;
  int            inj_last_beat = -1;
  bit            no_last = 1'b0;
  int            done_cnt = 0;
  int            ar_cnt = 0;
  int            stall_seen = 0;
  int            tb_out = 0;
  int            tb_lim = 1;
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  function automatic logic [7:0] beat_data(input logic [AW-1:0] a, input int b);
    return a[7:0] + 8'(b * 7 + 1);
  endfunction

  function automatic int end_idx(input burst_t bt);
    int e;
    e = int'(bt.len);
    if (inj_last_beat >= 0 && inj_last_beat < e)
      e = inj_last_beat;
    return e;
  endfunction

  // Slave model and AR scoreboard: sample at the edge, drive 1 time unit later.
  always @(posedge clk) begin
    if (!rst) begin
      if (prev_v && !prev_r) begin
        checks++;
        if (m_ar_valid !== 1'b1 || m_ar_addr !== prev_addr) begin
          failures++;
          $display("FAIL ar_hold: valid=%b addr=%h required valid=1 addr=%h", m_ar_valid, m_ar_addr, prev_addr);
        end
      end
      if (m_ar_valid === 1'b1) begin
        checks++;
        if (tb_out >= tb_lim) begin
          failures++;
          $display("FAIL ar_limit: valid with outstanding=%0d required below %0d", tb_out, tb_lim);
        end
        if (m_ar_ready !== 1'b1) stall_seen++;
      end
      if (m_ar_valid === 1'b1 && m_ar_ready === 1'b1) begin
        ar_cnt++;
        checks++;
        if (exp_ar.size() == 0) begin
          failures++;
          $display("FAIL ar_unexpected: addr=%h required no request", m_ar_addr);
        end else begin
          logic [AW-1:0] e;
          e = exp_ar.pop_front();
          if (m_ar_addr !== e || m_ar_len !== exp_len || m_ar_id !== exp_id) begin
            failures++;
            $display("FAIL ar_req: addr=%h len=%0d id=%0d required addr=%h len=%0d id=%0d",
                     m_ar_addr, m_ar_len, m_ar_id, e, exp_len, exp_id);
          end
        end
        rq.push_back('{addr: m_ar_addr, len: m_ar_len});
        tb_out++;
      end
      if (m_r_valid === 1'b1 && m_r_ready === 1'b1 && rq.size() > 0) begin
        if (beat >= end_idx(rq[0])) begin
          void'(rq.pop_front());
          beat = 0;
          tb_out--;
        end else begin
          beat++;
        end
      end
      if (done === 1'b1) done_cnt++;
      prev_v = m_ar_valid;
      prev_r = m_ar_ready;
      prev_addr = m_ar_addr;
    end else begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end
    #1;
    m_ar_ready = ar_ready_en && (ar_stall_cycles == 0);
    if (ar_stall_cycles > 0) ar_stall_cycles--;
    if (r_en && rq.size() > 0) begin
      m_r_valid = 1'b1;
      m_r_data  = beat_data(rq[0].addr, beat);
      m_r_id    = (beat == inj_id_beat) ? inj_id : exp_id;
      m_r_last  = (beat == end_idx(rq[0])) && !no_last;
    end else begin
      m_r_valid = 1'b0;
      m_r_last  = 1'b0;
    end
  end

  task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input logic [7:0] len, input logic [15:0] req,
                          input logic [7:0] id, input logic [3:0] lim);
    logic [AW-1:0] a;
    @(negedge clk);
    cfg_base_addr = base;
    cfg_stride = stride;
    cfg_len = len;
    cfg_req_num = req;
    cfg_id = id;
    cfg_outstanding_limit = lim;
    exp_len = len;
    exp_id = id;
    tb_lim = (lim == 4'd0) ? 1 : int'(lim);
    a = base;
    for (int k = 0; k < int'(req); k++) begin
      exp_ar.push_back(a);
      a = a + stride;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic logic [7:0] exp_sum(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                         input int len, input int req);
    logic [7:0]    s;
    logic [AW-1:0] a;
    s = 8'd0;
    a = base;
    for (int k = 0; k < req; k++) begin
      for (int b = 0; b <= len; b++) s = s ^ beat_data(a, b);
      a = a + stride;
    end
    return s;
  endfunction

  task automatic wait_done(input string name, input int max_cycles);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, max_cycles);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL %s_done_count: pulses=%0d required 1", name, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_ar_valid !== 1'b0 || m_ar_addr !== 16'h0 || m_ar_len !== 8'h0 || m_ar_id !== 8'h0) begin
      failures++;
      $display("FAIL reset_ar: valid=%b addr=%h len=%h id=%h required all 0", m_ar_valid, m_ar_addr, m_ar_len, m_ar_id);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_r_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b r_ready=%b required 0", busy, done, m_r_ready);
    end
    checks++;
    if (errorCode !== 3'b000 || beatCnt !== 16'h0 || dataChecksum !== 8'h0) begin
      failures++;
      $display("FAIL reset_counts: err=%b beats=%0d sum=%h required 0", errorCode, beatCnt, dataChecksum);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_result(input string name, input logic [15:0] beats,
                              input logic [2:0] err, input logic [7:0] sum, input bit chk_sum);
    checks++;
    if (beatCnt !== beats) begin
      failures++;
      $display("FAIL %s_beats: got %0d required %0d", name, beatCnt, beats);
    end
    checks++;
    if (errorCode !== err) begin
      failures++;
      $display("FAIL %s_err: got %b required %b", name, errorCode, err);
    end
    if (chk_sum) begin
      checks++;
      if (dataChecksum !== sum) begin
        failures++;
        $display("FAIL %s_sum: got %h required %h", name, dataChecksum, sum);
      end
    end
    checks++;
    if (exp_ar.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: pending_ars=%0d busy=%b required 0 and 0", name, exp_ar.size(), busy);
    end
  endtask

  task automatic test_basic();
    do_start(16'h0eef, 16'd3, 8'd5, 16'd3, 8'd5, 4'd3);
    wait_done("basic", 400);
    check_result("basic", 16'd18, 3'b000, exp_sum(16'h0eef, 16'd3, 5, 3), 1'b1);
  endtask

  task automatic test_ar_stall();
    int s0;
    s0 = stall_seen;
    @(negedge clk);
    ar_stall_cycles = 5;
    do_start(16'h0eef, 16'd3, 8'd5, 16'd3, 8'd5, 4'd1);
    wait_done("stall", 400);
    check_result("stall", 16'd18, 3'b000, exp_sum(16'h0eef, 16'd3, 5, 3), 1'b1);
    checks++;
    if (stall_seen - s0 < 3) begin
      failures++;
      $display("FAIL stall_cycles: stalled valid cycles=%0d required at least 3", stall_seen - s0);
    end
  endtask

  task automatic test_wrap();
    do_start(16'hfffe, 16'd3, 8'd1, 16'd2, 8'd5, 4'd2);
    r_stall = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (m_r_ready !== 1'b0 || beatCnt !== 16'd0) begin
      failures++;
      $display("FAIL rstall: r_ready=%b beats=%0d required 0 and 0", m_r_ready, beatCnt);
    end
    r_stall = 1'b0;
    wait_done("wrap", 400);
    check_result("wrap", 16'd4, 3'b000, exp_sum(16'hfffe, 16'd3, 1, 2), 1'b1);
  endtask

  task automatic test_errors();
    inj_id_beat = 1;
    inj_id = 8'd6;
    inj_last_beat = 3;
    do_start(16'h0100, 16'd4, 8'd5, 16'd1, 8'd5, 4'd1);
    wait_done("err_inject", 400);
    check_result("err_inject", 16'd4, 3'b011, 8'd0, 1'b0);
    inj_id_beat = -1;
    inj_last_beat = -1;
    do_start(16'h0200, 16'd4, 8'd2, 16'd1, 8'd5, 4'd1);
    checks++;
    if (errorCode !== 3'b000 || beatCnt !== 16'd0) begin
      failures++;
      $display("FAIL err_clear: err=%b beats=%0d required 000 and 0", errorCode, beatCnt);
    end
    wait_done("err_clean", 400);
    check_result("err_clean", 16'd3, 3'b000, exp_sum(16'h0200, 16'd4, 2, 1), 1'b1);
    no_last = 1'b1;
    do_start(16'h0300, 16'd16, 8'd2, 16'd2, 8'd5, 4'd2);
    wait_done("no_last", 400);
    check_result("no_last", 16'd6, 3'b100, exp_sum(16'h0300, 16'd16, 2, 2), 1'b1);
    no_last = 1'b0;
  endtask

  task automatic test_zero_req();
    int a0;
    int first_done;
    int pulses;
    bit any_valid;
    a0 = ar_cnt;
    first_done = 0;
    pulses = 0;
    any_valid = 1'b0;
    do_start(16'h1234, 16'd1, 8'd3, 16'd0, 8'd5, 4'd2);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (first_done == 0) first_done = i;
      end
      if (m_ar_valid !== 1'b0) any_valid = 1'b1;
    end
    checks++;
    if (pulses != 1 || first_done < 1 || first_done > 2) begin
      failures++;
      $display("FAIL zero_done: pulses=%0d at cycle %0d required 1 pulse within 2 cycles", pulses, first_done);
    end
    checks++;
    if (any_valid || ar_cnt != a0) begin
      failures++;
      $display("FAIL zero_ar: valid_seen=%b ars=%0d required none", any_valid, ar_cnt - a0);
    end
    do_start(16'h0400, 16'd16, 8'd3, 16'd2, 8'd5, 4'd1);
    repeat (3) @(negedge clk);
    cfg_base_addr = 16'h7777;
    cfg_req_num = 16'd9;
    cfg_id = 8'd9;
    cfg_len = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("midstart", 400);
    check_result("midstart", 16'd8, 3'b000, exp_sum(16'h0400, 16'd16, 3, 2), 1'b1);
  endtask

  task automatic test_reset_midrun();
    int a0;
    int d0;
    int n;
    r_en = 1'b0;
    a0 = ar_cnt;
    do_start(16'h0500, 16'd8, 8'd7, 16'd4, 8'd5, 4'd2);
    n = 0;
    while (ar_cnt - a0 < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ar_cnt - a0 != 2) begin
      failures++;
      $display("FAIL rst_setup: ars=%0d required 2", ar_cnt - a0);
    end
    @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_ar_valid !== 1'b0 || m_ar_addr !== 16'h0 || m_ar_len !== 8'h0 || m_ar_id !== 8'h0 ||
        busy !== 1'b0 || done !== 1'b0 || m_r_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl: valid=%b addr=%h len=%h id=%h busy=%b done=%b rready=%b required all 0",
               m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, busy, done, m_r_ready);
    end
    checks++;
    if (errorCode !== 3'b000 || beatCnt !== 16'h0 || dataChecksum !== 8'h0) begin
      failures++;
      $display("FAIL rst_mid_counts: err=%b beats=%0d sum=%h required 0", errorCode, beatCnt, dataChecksum);
    end
    rst = 1'b0;
    tb_out = 0;
    exp_ar.delete();
    r_en = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (beatCnt !== 16'h0 || errorCode !== 3'b000 || done_cnt != d0) begin
      failures++;
      $display("FAIL rst_stale_beats: beats=%0d err=%b dones=%0d required 0, 000, 0", beatCnt, errorCode, done_cnt - d0);
    end
    rq.delete();
    beat = 0;
    repeat (2) @(negedge clk);
    do_start(16'h0600, 16'd1, 8'd0, 16'd1, 8'd5, 4'd1);
    wait_done("post_rst", 200);
    check_result("post_rst", 16'd1, 3'b000, beat_data(16'h0600, 0), 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_base_addr = '0;
    cfg_stride = '0;
    cfg_len = '0;
    cfg_req_num = '0;
    cfg_id = '0;
    cfg_outstanding_limit = '0;
    r_stall = 1'b0;
    m_ar_ready = 1'b0;
    m_r_valid = 1'b0;
    m_r_last = 1'b0;
    m_r_data = '0;
    m_r_id = '0;
    test_reset();
    test_basic();
    test_ar_stall();
    test_wrap();
    test_errors();
    test_zero_req();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
